// File: rtl/input_conditioner.sv
// input_conditioner
// Synchronizes, debounces and edge-detects the board buttons and switches.
// Button strobes are suppressed after reset until each button has been seen
// genuinely released. A button held through reset therefore reports its level
// but gives no press or long-press strobe until it is released and pressed
// again.
//
// state        | meaning
// armed[b] = 0 | button b not yet seen released since reset; strobes blocked
// armed[b] = 1 | button b seen released; press / long-press strobes enabled

module input_conditioner #(
  parameter int DEB_CYCLES  = 20000,
  parameter int LONG_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTN1,
  input  logic       BTN6,
  input  logic       SW7,
  input  logic [6:0] SW,
  output logic       btn1_lvl,
  output logic       btn6_lvl,
  output logic       btn1_pulse,
  output logic       btn6_pulse,
  output logic       btn1_long,
  output logic       sw7_db,
  output logic [6:0] sw_db,
  output logic       sw_changed
);

  localparam int NI = 10;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  // Bit map shared by every per-input vector:
  // 0 = BTN1, 1 = BTN6, 2 = SW7, 3..9 = SW[0..6]
  logic [NI-1:0] raw;
  logic [NI-1:0] sync1;
  logic [NI-1:0] sync2;
  logic [NI-1:0] deb;
  logic [DW-1:0] deb_cnt [NI];
  logic [1:0]    sync_vld;
  logic [1:0]    armed;
  logic [LW-1:0] long_cnt;

  assign raw = {SW, SW7, BTN6, BTN1};

  // Two-flop synchronizers; sync_vld marks when sync2 holds real (post-reset) samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // Debounce: level follows the synchronized input after DEB_CYCLES disagreeing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < NI; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Arming: a button arms once a valid synchronized sample and its debounced level are both low
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= '0;
    end else begin
      armed <= armed | ({2{sync_vld[1]}} & ~sync2[1:0] & ~deb[1:0]);
    end
  end

  // Registered levels, press strobes and switch-change strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      btn1_lvl   <= 1'b0;
      btn6_lvl   <= 1'b0;
      btn1_pulse <= 1'b0;
      btn6_pulse <= 1'b0;
      sw7_db     <= 1'b0;
      sw_db      <= '0;
      sw_changed <= 1'b0;
    end else begin
      btn1_lvl   <= deb[0];
      btn6_lvl   <= deb[1];
      btn1_pulse <= deb[0] & ~btn1_lvl & armed[0];
      btn6_pulse <= deb[1] & ~btn6_lvl & armed[1];
      sw7_db     <= deb[2];
      sw_db      <= deb[9:3];
      sw_changed <= (deb[9:3] != sw_db);
    end
  end

  // Long press: count armed high cycles, strobe once on reaching LONG_CYCLES, then hold
  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt  <= '0;
      btn1_long <= 1'b0;
    end else if (!btn1_lvl) begin
      long_cnt  <= '0;
      btn1_long <= 1'b0;
    end else if (armed[0] && (long_cnt != LONG_MAX)) begin
      long_cnt  <= long_cnt + 1'b1;
      btn1_long <= (long_cnt == LONG_LAST);
    end else begin
      btn1_long <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a cycle-level reference model.
module tb_input_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int NI   = 10;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       BTN1 = 1'b0;
  logic       BTN6 = 1'b0;
  logic       SW7  = 1'b0;
  logic [6:0] SW   = '0;

  logic       btn1_lvl, btn6_lvl, btn1_pulse, btn6_pulse, btn1_long;
  logic       sw7_db, sw_changed;
  logic [6:0] sw_db;

  input_conditioner #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clk        (clk),
    .rst        (rst),
    .BTN1       (BTN1),
    .BTN6       (BTN6),
    .SW7        (SW7),
    .SW         (SW),
    .btn1_lvl   (btn1_lvl),
    .btn6_lvl   (btn6_lvl),
    .btn1_pulse (btn1_pulse),
    .btn6_pulse (btn6_pulse),
    .btn1_long  (btn1_long),
    .sw7_db     (sw7_db),
    .sw_db      (sw_db),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Inputs as seen by each rising edge
  logic [NI-1:0] raw_e;
  logic          rst_e;
  logic          seen_edge = 1'b0;

  always @(posedge clk) begin
    raw_e     <= {SW, SW7, BTN6, BTN1};
    rst_e     <= rst;
    seen_edge <= 1'b1;
  end

  // Reference model state
  logic [NI-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
  int            m_run [NI];
  int            m_since = 0;
  int            m_hi = 0;
  logic [1:0]    m_armed = '0, m_lvl = '0, m_pulse = '0;
  logic          m_long = 1'b0, m_sw7 = 1'b0, m_chg = 1'b0;
  logic [6:0]    m_sw = '0;

  // Event tallies used by the directed checks
  int edge_n = 0, p1_cnt = 0, p6_cnt = 0, long_cnt = 0, chg_cnt = 0;
  int last_p1 = 0, last_long = 0;

  task automatic model_step();
    logic [NI-1:0] deb_old, s2_old;
    logic [1:0]    lvl_old, armed_old;
    logic [6:0]    sw_old;
    deb_old   = m_deb;
    s2_old    = m_s2;
    lvl_old   = m_lvl;
    armed_old = m_armed;
    sw_old    = m_sw;
    if (rst_e) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      for (int i = 0; i < NI; i++) m_run[i] = 0;
      m_since = 0; m_hi = 0;
      m_armed = '0; m_lvl = '0; m_pulse = '0;
      m_long = 1'b0; m_sw7 = 1'b0; m_sw = '0; m_chg = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = raw_e;
      // a level flips after DEB consecutive samples that disagree with it
      for (int i = 0; i < NI; i++) begin
        if (s2_old[i] != deb_old[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_deb[i] = s2_old[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      for (int b = 0; b < 2; b++)
        if (m_since >= 2 && !s2_old[b] && !deb_old[b]) m_armed[b] = 1'b1;
      m_since++;
      m_lvl   = deb_old[1:0];
      m_pulse = m_lvl & ~lvl_old & armed_old;
      m_long  = 1'b0;
      if (!lvl_old[0]) m_hi = 0;
      else if (armed_old[0] && m_hi < LONG) begin
        m_hi++;
        m_long = (m_hi == LONG);
      end
      m_sw7 = deb_old[2];
      m_sw  = deb_old[9:3];
      m_chg = (m_sw != sw_old);
    end
  endtask

  // Per-cycle compare against the model, plus event tallies
  initial forever begin
    logic [13:0] got, exp;
    @(negedge clk);
    if (seen_edge) begin
      model_step();
      edge_n++;
      got = {btn1_lvl, btn6_lvl, btn1_pulse, btn6_pulse, btn1_long, sw7_db, sw_db, sw_changed};
      exp = {m_lvl[0], m_lvl[1], m_pulse[0], m_pulse[1], m_long, m_sw7, m_sw, m_chg};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got %b expected %b", edge_n, got, exp);
      end
      if (btn1_pulse === 1'b1) begin p1_cnt++; last_p1 = edge_n; end
      if (btn6_pulse === 1'b1) p6_cnt++;
      if (btn1_long === 1'b1) begin long_cnt++; last_long = edge_n; end
      if (sw_changed === 1'b1) chg_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {18'd0, btn1_lvl, btn6_lvl, btn1_pulse, btn6_pulse, btn1_long,
            sw7_db, sw_db, sw_changed};
  endfunction

  initial begin
    int p1_0, p6_0, l0, c0;

    rst = 1'b1;
    tick(3);
    check("reset outputs", all_outs(), 0);
    rst = 1'b0;
    tick(8);

    // BTN6 press: level after edge 6, single pulse
    BTN6 = 1'b1;
    tick(6);
    check("btn6_lvl before edge 6", btn6_lvl, 0);
    tick(1);
    check("btn6_lvl after edge 6", btn6_lvl, 1);
    check("btn6_pulse at edge 6", btn6_pulse, 1);
    tick(1);
    check("btn6_pulse one cycle", btn6_pulse, 0);
    check("btn6 pulse count", p6_cnt, 1);
    BTN6 = 1'b0;
    tick(10);

    // BTN1 glitching every 2 cycles: no level, no pulse
    for (int k = 0; k < 10; k++) begin
      BTN1 = 1'b1; tick(2);
      BTN1 = 1'b0; tick(2);
    end
    check("glitch btn1_lvl", btn1_lvl, 0);
    check("glitch btn1 pulses", p1_cnt, 0);
    tick(4);

    // BTN1 held 30 cycles: one pulse, one long 16 cycles later; repress gives new pulse
    p1_0 = p1_cnt; l0 = long_cnt;
    BTN1 = 1'b1;
    tick(30);
    check("hold pulse count", p1_cnt - p1_0, 1);
    check("hold long count", long_cnt - l0, 1);
    check("long delay after pulse", last_long - last_p1, 16);
    BTN1 = 1'b0;
    tick(10);
    check("btn1_lvl after release", btn1_lvl, 0);
    BTN1 = 1'b1;
    tick(10);
    check("repress pulse count", p1_cnt - p1_0, 2);
    check("repress no long", long_cnt - l0, 1);
    BTN1 = 1'b0;
    tick(10);

    // SW multi-bit change: one strobe, sw_db after edge 6
    c0 = chg_cnt;
    SW = 7'b1010101;
    tick(6);
    check("sw_db before edge 6", sw_db, 0);
    tick(1);
    check("sw_db after edge 6", sw_db, 7'b1010101);
    check("sw_changed at edge 6", sw_changed, 1);
    tick(5);
    check("sw_changed count", chg_cnt - c0, 1);

    // SW7 does not strobe sw_changed
    SW7 = 1'b1;
    tick(10);
    check("sw7_db", sw7_db, 1);
    check("sw7 no sw_changed", chg_cnt - c0, 1);

    // BTN1 and switches held through reset
    BTN1 = 1'b1;
    SW   = 7'b0110011;
    rst  = 1'b1;
    tick(3);
    check("reset with inputs high", all_outs(), 0);
    p1_0 = p1_cnt; l0 = long_cnt; c0 = chg_cnt;
    rst = 1'b0;
    tick(6);
    check("held btn1_lvl before edge 6", btn1_lvl, 0);
    tick(1);
    check("held btn1_lvl after edge 6", btn1_lvl, 1);
    check("held btn1 no pulse", btn1_pulse, 0);
    check("held sw_db", sw_db, 7'b0110011);
    check("held sw7_db", sw7_db, 1);
    tick(25);
    check("held no pulses", p1_cnt - p1_0, 0);
    check("held no long", long_cnt - l0, 0);
    check("held sw_changed once", chg_cnt - c0, 1);
    BTN1 = 1'b0;
    tick(10);
    BTN1 = 1'b1;
    tick(10);
    check("held release repress pulse", p1_cnt - p1_0, 1);
    BTN1 = 1'b0;
    tick(10);

    // Reset on edge 3 of a BTN6 press
    p6_0 = p6_cnt;
    BTN6 = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("reset mid-debounce outputs", all_outs(), 0);
    tick(1);
    rst = 1'b0;
    tick(10);
    check("post reset btn6_lvl", btn6_lvl, 1);
    check("post reset btn6 no pulse", p6_cnt - p6_0, 0);
    BTN6 = 1'b0;
    tick(10);
    BTN6 = 1'b1;
    tick(10);
    check("btn6 repress pulse", p6_cnt - p6_0, 1);
    BTN6 = 1'b0;
    tick(10);

    // Reset in the middle of a long press abandons it
    p1_0 = p1_cnt; l0 = long_cnt;
    BTN1 = 1'b1;
    tick(12);
    check("mid-long pulse", p1_cnt - p1_0, 1);
    rst = 1'b1;
    tick(2);
    BTN1 = 1'b0;
    rst  = 1'b0;
    tick(30);
    check("aborted long press", long_cnt - l0, 0);
    check("aborted btn1_lvl", btn1_lvl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
